// File: rtl/iob_wishbone2iob.sv
// iob_wishbone2iob: Wishbone classic-cycle slave bridged to an IOb master port, one transaction in flight,
// with a response timeout that terminates the cycle with wb_err_o.
module iob_wishbone2iob #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W/8-1:0] wb_select_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic                wb_ack_o,
  output logic                wb_err_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);
  typedef enum logic [1:0] {IDLE, REQ, RWAIT, DONE} state_t;
  state_t state;
  logic [TIMEOUT_W-1:0] cnt, cnt_nx;
  logic ack_r, err_r, to;
  assign cnt_nx = cnt + TIMEOUT_W'(1);
  // timeout fires on the edge where the counter reaches its all-ones value
  assign to = &cnt_nx;
  assign wb_ack_o = ack_r & wb_cyc_i;
  assign wb_err_o = err_r & wb_cyc_i;
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state        <= IDLE;
      cnt          <= '0;
      ack_r        <= 1'b0;
      err_r        <= 1'b0;
      iob_avalid_o <= 1'b0;
      iob_addr_o   <= '0;
      iob_wdata_o  <= '0;
      iob_wstrb_o  <= '0;
      wb_data_o    <= '0;
    end else if (cke_i) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      case (state)
        IDLE: if (wb_cyc_i && wb_stb_i) begin
          state        <= REQ;
          cnt          <= '0;
          iob_avalid_o <= 1'b1;
          iob_addr_o   <= wb_addr_i;
          iob_wdata_o  <= wb_data_i;
          iob_wstrb_o  <= wb_we_i ? wb_select_i : '0;
        end
        REQ: begin
          cnt <= iob_ready_i ? '0 : cnt_nx;
          if (iob_ready_i) begin
            iob_avalid_o <= 1'b0;
            state        <= (|iob_wstrb_o) ? DONE : RWAIT;
            ack_r        <= |iob_wstrb_o;
          end else if (to) begin
            iob_avalid_o <= 1'b0;
            err_r        <= 1'b1;
            state        <= IDLE;
          end
        end
        RWAIT: begin
          cnt <= cnt_nx;
          if (iob_rvalid_i) begin
            wb_data_o <= iob_rdata_i;
            ack_r     <= 1'b1;
            state     <= DONE;
          end else if (to) begin
            err_r <= 1'b1;
            state <= IDLE;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule
